// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle signed divider. Radix-2 restoring division on
//                operand magnitudes (one quotient bit per cycle), followed by
//                a sign-fix cycle. Quotient -> lo, remainder -> hi.
//                Divide-by-zero short-circuits straight to DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_dvs_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_ok;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Magnitudes in WIDTH bits: the most negative value maps onto itself and
    // is then treated as an unsigned magnitude, which gives the wrap result.
    assign w_dvd_abs  = dividend[WIDTH-1] ? (-dividend) : dividend;
    assign w_dvs_abs  = divisor[WIDTH-1]  ? (-divisor)  : divisor;
    assign w_dvs_zero = (divisor == '0);

    // One restoring step: shift {rem,q} left, then try subtracting the divisor.
    // rem < divisor always holds, so WIDTH+1 bits cannot overflow.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_trial_ok = ~w_trial[WIDTH];

    // Sign fix: quotient negative if operand signs differ, remainder follows dividend.
    assign w_q_fix = r_sign_q ? (-r_q)   : r_q;
    assign w_r_fix = r_sign_r ? (-r_rem) : r_rem;

    // Control FSM plus datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvsr   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dvs_zero) begin
                            r_lo    <= '1;
                            r_hi    <= dividend;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_q      <= w_dvd_abs;
                            r_dvsr   <= w_dvs_abs;
                            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sign_r <= dividend[WIDTH-1];
                            r_rem    <= '0;
                            r_cnt    <= C_CNT_LAST;
                            r_dbz    <= 1'b0;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_trial_ok) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_lo    <= w_q_fix;
                    r_hi    <= w_r_fix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider: directed vector table,
//                hand-written multi-cycle sequences and randomized operations
//                checked against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: signed arithmetic truncating toward zero, remainder follows dividend.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            z = 1'b0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    // Issue one operation from a negedge and check latency, results and the pulse.
    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic ez, input int elat);
        int lat;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        @(negedge clk);
        chk({nm, "_busy_first"}, {31'd0, busy}, {31'd0, (elat != 0)});
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_lo"}, lo, elo);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({nm, "_lo_hold"}, lo, elo);
    endtask

    initial begin
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33};
        vecs[2] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
        vecs[4] = '{32'd55,         32'd0,          32'hFFFF_FFFF,  32'd55,         1'b1, 0};
        vecs[5] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        chk("rst_hi",   hi, 32'd0);
        chk("rst_lo",   lo, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_z, vecs[i].exp_lat);
        end

        // Start during RUN and operand changes must be ignored; one done pulse.
        begin
            int pulses;
            int first;
            pulses = 0;
            first  = -1;
            start    = 1'b1;
            dividend = 32'd1000;
            divisor  = 32'd10;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int n = 0; n < 45; n++) begin
                @(negedge clk);
                if (n == 5) begin
                    start    = 1'b1;
                    dividend = 32'd7;
                    divisor  = 32'd7;
                end
                if (n == 8) start = 1'b0;
                if (n == 20) chk("busy_lo_hold", lo, 32'd3);
                if (done) begin
                    pulses++;
                    if (first < 0) first = n;
                end
            end
            chk("busy_pulses", 32'(pulses), 32'd1);
            chk("busy_latency", 32'(first), 32'd33);
            chk("busy_lo", lo, 32'd100);
            chk("busy_hi", hi, 32'd0);
        end

        // Reset mid-operation discards the division and clears results.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi",   hi, 32'd0);
        chk("midrst_lo",   lo, 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_idle_done", {31'd0, done}, 32'd0);
        do_op("after_rst", 32'd21, 32'd4, 32'd5, 32'd1, 1'b0, 33);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] q;
            logic [31:0] r;
            logic        z;
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            model(a, b, q, r, z);
            do_op($sformatf("rnd%0d", i), a, b, q, r, z, z ? 0 : 33);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
